// File: rtl/onehot_index_scanner_if.sv
// Handshake and mask bus between a mask producer/index consumer and the scanner.
// master = the side that loads masks and accepts indices; slave = the scanner.
interface onehot_index_scanner_if;
    logic        load;
    logic        clear;
    logic [31:0] mask;
    logic        busy;
    logic        idx_valid;
    logic [4:0]  idx;
    logic        idx_ready;
    logic        done;
    logic [5:0]  remaining;

    // idx transfers on a cycle where idx_valid && idx_ready are both high at the
    // rising clock edge; idx_valid never drops without a transfer except on clear/rst.
    modport master (
        output load, clear, mask, idx_ready,
        input  busy, idx_valid, idx, done, remaining
    );

    modport slave (
        input  load, clear, mask, idx_ready,
        output busy, idx_valid, idx, done, remaining
    );
endinterface

// File: rtl/onehot_index_scanner.sv
// Serialising encoder: latches a 32-bit mask and hands out the index of each set
// bit, one per handshake, in priority order, then pulses done.
module onehot_index_scanner #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    onehot_index_scanner_if.slave         bus,
    output logic [1:0]                    state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] pending_after;
    logic [4:0]  sel_idx;
    logic [5:0]  pop_cnt;
    logic        accept;

    // Priority pick: the last match in loop order wins, so the loop direction
    // is opposite to the emission order.
    always_comb begin
        sel_idx = 5'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 32; i++) begin
                if (pending_q[i]) sel_idx = 5'(i);
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                if (pending_q[i]) sel_idx = 5'(i);
            end
        end
    end

    always_comb begin
        pop_cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            pop_cnt = pop_cnt + 6'(pending_q[i]);
        end
    end

    assign accept        = (state_q == S_SCAN) && bus.idx_ready;
    assign pending_after = pending_q & ~(32'd1 << sel_idx);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    pending_d = bus.mask;
                    state_d   = (bus.mask == 32'd0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (accept) begin
                    pending_d = pending_after;
                    if (pending_after == 32'd0) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d   = S_IDLE;
                pending_d = 32'd0;
            end
        endcase
        // Abort wins over load and acceptance; no done pulse follows.
        if (bus.clear) begin
            state_d   = S_IDLE;
            pending_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // All outputs derive from registered state only.
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.idx_valid = (state_q == S_SCAN);
    assign bus.idx       = (state_q == S_SCAN) ? sel_idx : 5'd0;
    assign bus.done      = (state_q == S_DONE);
    assign bus.remaining = pop_cnt;
    assign state_o       = state_q;
endmodule

// File: tb/tb_onehot_index_scanner.sv
// Bench for onehot_index_scanner: an LSB-first and an MSB-first instance share
// one stimulus stream and are checked every cycle against a queue-based model.
module tb_onehot_index_scanner;
    logic        clk;
    logic        rst;
    logic        load_r, clear_r, ready_r;
    logic [31:0] mask_r;
    logic [1:0]  state0, state1;

    int total;
    int bad;

    onehot_index_scanner_if bus0 ();
    onehot_index_scanner_if bus1 ();

    assign bus0.load = load_r;  assign bus0.clear = clear_r;
    assign bus0.mask = mask_r;  assign bus0.idx_ready = ready_r;
    assign bus1.load = load_r;  assign bus1.clear = clear_r;
    assign bus1.mask = mask_r;  assign bus1.idx_ready = ready_r;

    onehot_index_scanner #(.MSB_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .bus(bus0), .state_o(state0)
    );
    onehot_index_scanner #(.MSB_FIRST(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .bus(bus1), .state_o(state1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending indices are kept as queues in emission order; the phase is the
    // spec's idle / scanning / done-pulse condition.
    int q_lo[$];
    int q_hi[$];
    int m_phase;  // 0 idle, 1 scanning, 2 done pulse

    task automatic model_reset();
        q_lo.delete();
        q_hi.delete();
        m_phase = 0;
    endtask

    task automatic model_step(input logic ld, input logic clr, input logic rdy,
                              input logic [31:0] m);
        if (clr) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (ld) begin
                for (int i = 0; i < 32; i++) begin
                    if (m[i]) begin
                        q_lo.push_back(i);
                        q_hi.push_front(i);
                    end
                end
                m_phase = (q_lo.size() == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (rdy) begin
                void'(q_lo.pop_front());
                void'(q_hi.pop_front());
                if (q_lo.size() == 0) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the
    // DUT will sample on the next rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            check("lo.busy",      32'(bus0.busy),      32'(m_phase != 0));
            check("lo.idx_valid", 32'(bus0.idx_valid), 32'(m_phase == 1));
            check("lo.idx",       32'(bus0.idx),       (m_phase == 1) ? 32'(q_lo[0]) : 32'd0);
            check("lo.done",      32'(bus0.done),      32'(m_phase == 2));
            check("lo.remaining", 32'(bus0.remaining), 32'(q_lo.size()));
            check("hi.busy",      32'(bus1.busy),      32'(m_phase != 0));
            check("hi.idx_valid", 32'(bus1.idx_valid), 32'(m_phase == 1));
            check("hi.idx",       32'(bus1.idx),       (m_phase == 1) ? 32'(q_hi[0]) : 32'd0);
            check("hi.done",      32'(bus1.done),      32'(m_phase == 2));
            check("hi.remaining", 32'(bus1.remaining), 32'(q_hi.size()));
            if (!rst) model_step(load_r, clear_r, ready_r, mask_r);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [31:0] lo_idx, input logic [31:0] hi_idx,
                       input logic [31:0] rem, input logic [31:0] valid);
        check({name, ".lo_idx"}, 32'(bus0.idx), lo_idx);
        check({name, ".hi_idx"}, 32'(bus1.idx), hi_idx);
        check({name, ".rem"},    32'(bus0.remaining), rem);
        check({name, ".valid"},  32'(bus0.idx_valid), valid);
    endtask

    task automatic pin_done(input string name, input logic [31:0] d, input logic [31:0] b);
        check({name, ".done"}, 32'(bus0.done), d);
        check({name, ".busy"}, 32'(bus0.busy), b);
        check({name, ".hi_done"}, 32'(bus1.done), d);
    endtask

    task automatic do_load(input logic [31:0] m);
        load_r = 1'b1;
        mask_r = m;
        tick();
        load_r = 1'b0;
    endtask

    function automatic logic [31:0] gen_mask();
        logic [31:0] m;
        case ($urandom_range(0, 5))
            0:       m = 32'd0;
            1:       m = 32'hFFFF_FFFF;
            2:       m = 32'd1 << $urandom_range(0, 31);
            3:       m = $urandom;
            4:       m = $urandom & $urandom & $urandom;
            default: m = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        endcase
        return m;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        load_r = 1'b0;
        clear_r = 1'b0;
        ready_r = 1'b1;
        mask_r = 32'd0;
        tick();
        pin("reset", 0, 0, 0, 0);
        pin_done("reset", 0, 0);
        tick();
        rst = 1'b0;
        tick();

        // Two-bit mask at both ends of the word.
        do_load(32'h8000_0001);
        pin("ends.c1", 0, 31, 2, 1);
        tick();
        pin("ends.c2", 31, 0, 1, 1);
        tick();
        pin_done("ends.done", 1, 1);
        tick();
        pin_done("ends.idle", 0, 0);

        // All-ones mask: 32 back-to-back indices.
        do_load(32'hFFFF_FFFF);
        pin("ones.first", 0, 31, 32, 1);
        for (int i = 1; i < 32; i++) tick();
        pin("ones.last", 31, 0, 1, 1);
        tick();
        pin_done("ones.done", 1, 1);
        tick();

        // Zero mask: done straight away, never valid.
        do_load(32'h0);
        pin("zero", 0, 0, 0, 0);
        pin_done("zero", 1, 1);
        tick();
        pin_done("zero.idle", 0, 0);

        // Backpressure with an ignored mid-scan load.
        do_load(32'h0000_0290);
        ready_r = 1'b1;
        pin("bp.c1", 4, 9, 3, 1);
        tick();
        ready_r = 1'b0;
        load_r = 1'b1;
        mask_r = 32'hFFFF_FFFF;
        pin("bp.c2", 7, 7, 2, 1);
        tick();
        load_r = 1'b0;
        pin("bp.c3", 7, 7, 2, 1);
        tick();
        ready_r = 1'b1;
        pin("bp.c4", 7, 7, 2, 1);
        tick();
        pin("bp.c5", 9, 4, 1, 1);
        tick();
        pin_done("bp.done", 1, 1);
        tick();
        pin_done("bp.idle", 0, 0);

        // Clear while an index is valid.
        do_load(32'h00F0_0000);
        pin("clr.c1", 20, 23, 4, 1);
        tick();
        pin("clr.c2", 21, 22, 3, 1);
        clear_r = 1'b1;
        tick();
        clear_r = 1'b0;
        pin("clr.after", 0, 0, 0, 0);
        pin_done("clr.after", 0, 0);
        do_load(32'h1);
        pin("clr.reload", 0, 0, 1, 1);
        tick();
        pin_done("clr.reload_done", 1, 1);
        tick();

        // Asynchronous reset mid-scan.
        do_load(32'h0000_FF00);
        pin("rst.c1", 8, 15, 8, 1);
        tick();
        #2 rst = 1'b1;
        #1;
        pin("rst.async", 0, 0, 0, 0);
        pin_done("rst.async", 0, 0);
        tick();
        rst = 1'b0;
        tick();
        pin_done("rst.idle", 0, 0);
        do_load(32'h2);
        pin("rst.reload", 1, 1, 1, 1);
        tick();
        pin_done("rst.reload_done", 1, 1);
        tick();

        // Randomized traffic checked by the model.
        for (int c = 0; c < 4000; c++) begin
            ready_r = ($urandom_range(0, 3) != 0);
            clear_r = ($urandom_range(0, 80) == 0);
            load_r  = ($urandom_range(0, 2) == 0);
            mask_r  = gen_mask();
            tick();
        end
        load_r = 1'b0;
        clear_r = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/onehot_index_scanner.md
# onehot_index_scanner

Serialising encoder for the register-file path. It latches a 32-bit one-hot or multi-hot register mask and emits the 5-bit index of each set bit, one per handshake, in priority order, then pulses `done`. It is the reverse of the 5-to-32 select decoder: it turns dirty/valid/scoreboard masks back into register numbers for writeback, flush or spill sequencing.

## Interface
- `MSB_FIRST`, default 0: 0 emits indices lowest bit first; 1 emits highest bit first.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `load`  in  1  capture `mask`; honoured only in IDLE.
- `clear`  in  1  synchronous abort to IDLE; no `done` pulse.
- `mask`  in  32  bit vector to scan; sampled only on an accepted load.
- `busy`  out  1  high in SCAN and DONE.
- `idx_valid`  out  1  `idx` is a valid index awaiting acceptance.
- `idx`  out  5  current index, bit n → value n.
- `idx_ready`  in  1  consumer accepts `idx` when it is high together with `idx_valid`.
- `done`  out  1  one-cycle pulse after the last index is accepted, or after loading an all-zero mask.
- `remaining`  out  6  popcount of the bits not yet accepted (0..32).

## Operation
- Internal state: `pending[31:0]` register and FSM {IDLE, SCAN, DONE}.
- **IDLE**
  - `load=1` sets `pending<=mask`.
  - If `mask==0`, go to DONE; otherwise go to SCAN.
- **SCAN**
  - `idx_valid=1`.
  - `idx` = position of the lowest set bit of `pending` (highest if `MSB_FIRST=1`).
  - On `idx_valid && idx_ready`, that bit of `pending` is cleared.
  - If `pending` becomes 0, go to DONE.
  - Otherwise stay in SCAN; the next index is presented in the following cycle.
- **DONE**: `done=1` for exactly one cycle, then unconditionally go to IDLE.
- `load` outside IDLE is ignored; `pending` and the sequence are unaffected.
- `clear=1` in any state: next state is IDLE and `pending<=0`.
  - `clear` has priority over `load` and over an acceptance in the same cycle.
  - An index accepted in a cycle where `clear=1` still counts as transferred to the consumer.
  - No `done` pulse follows a `clear`.
- `idx`, `idx_valid` and `remaining` depend only on registered state; there is no combinational path from any input.
- `idx` is 0 whenever `idx_valid=0`.
- `remaining` = popcount(`pending`), 6 bits wide, and holds 32 for an all-ones mask.
- Each set bit is emitted exactly once. Indices are strictly increasing (or strictly decreasing when `MSB_FIRST=1`).

## Timing
- Reset values:
  - FSM = IDLE, `pending` = 0.
  - `busy`=0, `idx_valid`=0, `idx`=0, `done`=0, `remaining`=0.
- Load latency: `load` sampled at edge k puts `idx_valid` high from edge k onward (first index visible in cycle k+1).
- Throughput: one index per cycle while `idx_ready` is held high.
  - An N-bit mask with N ≥ 1 gives N valid cycles, then a `done` pulse in the cycle after the last acceptance.
  - The block is back in IDLE the cycle after that.
  - A new `load` is accepted in the first IDLE cycle.
- Zero mask: `load` at edge k gives `done=1` in cycle k+1 and no `idx_valid`.
- Backpressure:
  - While `idx_valid && !idx_ready`, `idx`, `pending` and `remaining` hold stable.
  - `idx_valid` never drops without an acceptance, except on `clear` or `rst`.
- Reset mid-operation: asserting `rst` immediately (asynchronously) forces all outputs to their reset values. After deassertion the block is in IDLE and the old sequence is not resumed.

## Test plan
- Mask 0x8000_0001, `idx_ready`=1, `MSB_FIRST`=0 → `idx` 0 then 31 on consecutive cycles, `remaining` 2→1, then a `done` pulse, then IDLE.
- Mask 0xFFFF_FFFF, `idx_ready`=1 → 32 back-to-back indices 0..31, `remaining` 32→1, `done` in the cycle after `idx`=31. With `MSB_FIRST`=1 → indices 31..0.
- Mask 0x0000_0000 loaded → `done`=1 one cycle later, `idx_valid` never asserted, `busy` high for one cycle.
- Mask 0x0000_0290, `idx_ready` toggled 1,0,0,1,1 → `idx` 4, then 7 held for two stalled cycles, then 9. A `load` of 0xFFFF_FFFF issued mid-scan is ignored.
- Mask 0x00F0_0000; after accepting 20, pulse `clear` while `idx`=21 is valid → IDLE next cycle, `remaining`=0, no `done`. A following `load` of 0x1 → `idx` 0.
- Assert `rst` asynchronously mid-scan of 0x0000_FF00 → outputs go to 0 immediately. After release, a `load` of 0x2 → `idx` 1, then `done`.
